compare_unit_iter: RTL and testbench

- Parametrised, multi-cycle comparator for R/I-type compare and branch-condition ops.
- Compares operands CHUNK bits per cycle, MSB chunk first.
- Handles signed/unsigned less-than, greater-or-equal, equality, and signed min/max.
- Sits between the decode/issue stage and writeback, with valid/ready handshakes on both sides and a pipeline flush input.

---
 rtl/compare_unit_iter_if.sv | 26 ++
 rtl/compare_unit_iter.sv | 179 +++++++++++++++++
 tb/tb_compare_unit_iter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/compare_unit_iter_if.sv
// Request/response bundle for compare_unit_iter: issue-side request, writeback-side
// result, flush and busy status.
interface compare_unit_iter_if #(
   parameter int WIDTH = 32
);
   logic             flush_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] op_a_i;
   logic [WIDTH-1:0] op_b_i;
   logic [2:0]       opcode_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] result_o;
   logic             busy_o;

   modport slave (
      input  flush_i, in_valid_i, op_a_i, op_b_i, opcode_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, busy_o
   );

   modport master (
      output flush_i, in_valid_i, op_a_i, op_b_i, opcode_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, busy_o
   );
endinterface

// File: rtl/compare_unit_iter.sv
// Multi-cycle compare/min/max unit, CHUNK bits per cycle, MSB chunk first.
// Optional macro COMPARE_UNIT_ITER_EARLY_EXIT_EN: finish on the first differing chunk.
//
// state | meaning
// IDLE  | ready for a request, operands latched on accept
// BUSY  | comparing one chunk per cycle
// DONE  | result held valid until consumed or flushed
module compare_unit_iter #(
   parameter int               WIDTH                 = 32,
   parameter int               CHUNK                 = 8,
   parameter logic [WIDTH-1:0] UNKNOWN_OPCODE_RESULT = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   compare_unit_iter_if.slave bus
);
   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [2:0] OP_SLT  = 3'b000;
   localparam logic [2:0] OP_SLTU = 3'b001;
   localparam logic [2:0] OP_EQ   = 3'b010;
   localparam logic [2:0] OP_NE   = 3'b011;
   localparam logic [2:0] OP_SGE  = 3'b100;
   localparam logic [2:0] OP_SGEU = 3'b101;
   localparam logic [2:0] OP_MIN  = 3'b110;
   localparam logic [2:0] OP_MAX  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2:0]         opcode_q, opcode_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               lt_q, lt_d;
   logic               gt_q, gt_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               signed_op;
   logic [WIDTH-1:0]   cmp_a;
   logic [WIDTH-1:0]   cmp_b;
   logic [CHUNK-1:0]   chunk_a;
   logic [CHUNK-1:0]   chunk_b;
   logic               decided;
   logic               chunk_lt;
   logic               chunk_gt;
   logic               last_chunk;
   logic               finish;

   function automatic logic [WIDTH-1:0] make_result(
      input logic [2:0]       op,
      input logic             lt,
      input logic             gt,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH-1:0] r;
      r = '0;
      case (op)
         OP_SLT, OP_SLTU: r[0] = lt;
         OP_EQ:           r[0] = !lt && !gt;
         OP_NE:           r[0] = lt || gt;
         OP_SGE, OP_SGEU: r[0] = !lt;
         OP_MIN:          r    = lt ? a : b;
         OP_MAX:          r    = gt ? a : b;
         default:         r    = UNKNOWN_OPCODE_RESULT;
      endcase
      return r;
   endfunction

   // Flipping both sign bits maps two's-complement order onto unsigned order.
   always_comb begin
      signed_op = (opcode_q == OP_SLT) || (opcode_q == OP_SGE) || (opcode_q[2:1] == 2'b11);
      cmp_a     = a_q;
      cmp_b     = b_q;
      if (signed_op) begin
         cmp_a[WIDTH-1] = ~a_q[WIDTH-1];
         cmp_b[WIDTH-1] = ~b_q[WIDTH-1];
      end
   end

   // idx 0 addresses the most significant chunk.
   always_comb begin
      chunk_a = '0;
      chunk_b = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IDX_W'(i)) begin
            chunk_a = cmp_a[(N-1-i)*CHUNK +: CHUNK];
            chunk_b = cmp_b[(N-1-i)*CHUNK +: CHUNK];
         end
      end
   end

   always_comb begin
      decided    = lt_q || gt_q;
      chunk_lt   = !decided && (chunk_a < chunk_b);
      chunk_gt   = !decided && (chunk_a > chunk_b);
      last_chunk = (idx_q == IDX_W'(N - 1));
`ifdef COMPARE_UNIT_ITER_EARLY_EXIT_EN
      finish     = last_chunk || chunk_lt || chunk_gt;
`else
      finish     = last_chunk;
`endif
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      opcode_d = opcode_q;
      idx_d    = idx_q;
      lt_d     = lt_q;
      gt_d     = gt_q;
      result_d = result_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid_i && !bus.flush_i) begin
               a_d      = bus.op_a_i;
               b_d      = bus.op_b_i;
               opcode_d = bus.opcode_i;
               idx_d    = '0;
               lt_d     = 1'b0;
               gt_d     = 1'b0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (bus.flush_i) begin
               state_d = IDLE;
            end else begin
               lt_d  = lt_q || chunk_lt;
               gt_d  = gt_q || chunk_gt;
               idx_d = idx_q + IDX_W'(1);
               if (finish) begin
                  result_d = make_result(opcode_q, lt_d, gt_d, a_q, b_q);
                  state_d  = DONE;
               end
            end
         end
         DONE: begin
            if (bus.flush_i || bus.out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         opcode_q <= '0;
         idx_q    <= '0;
         lt_q     <= 1'b0;
         gt_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opcode_q <= opcode_d;
         idx_q    <= idx_d;
         lt_q     <= lt_d;
         gt_q     <= gt_d;
         result_q <= result_d;
      end
   end

   assign bus.in_ready_o  = (state_q == IDLE);
   assign bus.out_valid_o = (state_q == DONE);
   assign bus.busy_o      = (state_q != IDLE);
   assign bus.result_o    = result_q;
endmodule

// File: tb/tb_compare_unit_iter.sv
// Randomised and directed bench for compare_unit_iter against an arithmetic reference model.
module tb_compare_unit_iter;
   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int N     = WIDTH / CHUNK;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   vectors = 0;
   int   errors  = 0;

   always #5 clk_i = ~clk_i;

   compare_unit_iter_if #(.WIDTH(WIDTH)) bus ();

   compare_unit_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [2:0] op);
      logic [WIDTH-1:0] r;
      r = '0;
      case (op)
         3'd0: r[0] = ($signed(a) < $signed(b));
         3'd1: r[0] = (a < b);
         3'd2: r[0] = (a == b);
         3'd3: r[0] = (a != b);
         3'd4: r[0] = ($signed(a) >= $signed(b));
         3'd5: r[0] = (a >= b);
         3'd6: r = ($signed(a) < $signed(b)) ? a : b;
         default: r = ($signed(a) > $signed(b)) ? a : b;
      endcase
      return r;
   endfunction

   function automatic int model_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef COMPARE_UNIT_ITER_EARLY_EXIT_EN
      for (int i = 0; i < N; i++) begin
         if (((a >> ((N - 1 - i) * CHUNK)) & ((1 << CHUNK) - 1)) !=
             ((b >> ((N - 1 - i) * CHUNK)) & ((1 << CHUNK) - 1)))
            return i + 1;
      end
      return N;
`else
      return N;
`endif
   endfunction

   // Issue one op from IDLE and wait (bounded) for out_valid; leaves the result unconsumed.
   task automatic issue_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] op, output int lat);
      @(negedge clk_i);
      bus.in_valid_i = 1'b1;
      bus.op_a_i     = a;
      bus.op_b_i     = b;
      bus.opcode_i   = op;
      @(posedge clk_i);
      #1;
      bus.in_valid_i = 1'b0;
      lat = 0;
      while (!bus.out_valid_o && lat < 20) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
   endtask

   task automatic consume();
      @(negedge clk_i);
      bus.out_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.out_ready_i = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op);
      int lat;
      logic [WIDTH-1:0] exp_r;
      int exp_l;
      exp_r = model(a, b, op);
      exp_l = model_latency(a, b);
      vectors++;
      if (bus.in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before: in_ready=%b required 1", name, bus.in_ready_o);
      end
      issue_and_wait(a, b, op, lat);
      vectors++;
      if (lat != exp_l) begin
         errors++;
         $display("FAIL %s latency: got %0d required %0d (a=%h b=%h op=%0d)", name, lat, exp_l, a, b, op);
      end
      vectors++;
      if (bus.result_o !== exp_r) begin
         errors++;
         $display("FAIL %s result: got %h required %h (a=%h b=%h op=%0d)", name, bus.result_o, exp_r, a, b, op);
      end
      consume();
      vectors++;
      if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s release: ready=%b valid=%b busy=%b required 1 0 0", name,
                  bus.in_ready_o, bus.out_valid_o, bus.busy_o);
      end
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b busy=%b result=%h required 0 0 0",
                  bus.out_valid_o, bus.busy_o, bus.result_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      vectors++;
      if (bus.in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b required 1", bus.in_ready_o);
      end
   endtask

   task automatic test_directed();
      run_op("slt",   32'hFFFFFFFF, 32'h00000001, 3'd0);
      run_op("sltu",  32'hFFFFFFFF, 32'h00000001, 3'd1);
      run_op("sgeu",  32'hFFFFFFFF, 32'h00000001, 3'd5);
      run_op("eq",    32'h12345678, 32'h12345678, 3'd2);
      run_op("ne",    32'h12345678, 32'h12345678, 3'd3);
      run_op("min",   32'h80000000, 32'h7FFFFFFF, 3'd6);
      run_op("max",   32'h80000000, 32'h7FFFFFFF, 3'd7);
      run_op("sge",   32'h00000100, 32'h000000FF, 3'd4);
      run_op("sge_eq",32'hDEADBEEF, 32'hDEADBEEF, 3'd4);
   endtask

   task automatic test_backpressure();
      int lat;
      logic [WIDTH-1:0] exp_r;
      exp_r = model(32'h00000005, 32'hFFFFFFF0, 3'd7);
      issue_and_wait(32'h00000005, 32'hFFFFFFF0, 3'd7, lat);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk_i);
         #1;
         vectors++;
         if (bus.out_valid_o !== 1'b1 || bus.result_o !== exp_r || bus.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold: valid=%b result=%h ready=%b required 1 %h 0",
                     bus.out_valid_o, bus.result_o, bus.in_ready_o, exp_r);
         end
      end
      // A request offered while DONE must be ignored.
      @(negedge clk_i);
      bus.in_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.in_valid_i = 1'b0;
      vectors++;
      if (bus.out_valid_o !== 1'b1 || bus.result_o !== exp_r) begin
         errors++;
         $display("FAIL done_ignores_req: valid=%b result=%h required 1 %h", bus.out_valid_o, bus.result_o, exp_r);
      end
      consume();
      vectors++;
      if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_release: ready=%b valid=%b required 1 0", bus.in_ready_o, bus.out_valid_o);
      end
   endtask

   task automatic test_flush();
      int seen;
      @(negedge clk_i);
      bus.in_valid_i = 1'b1;
      bus.op_a_i     = 32'h12345678;
      bus.op_b_i     = 32'h12345678;
      bus.opcode_i   = 3'd2;
      @(posedge clk_i);
      #1;
      bus.in_valid_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      bus.flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.flush_i = 1'b0;
      vectors++;
      if (bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_busy: busy=%b ready=%b valid=%b required 0 1 0",
                  bus.busy_o, bus.in_ready_o, bus.out_valid_o);
      end
      seen = 0;
      for (int c = 0; c < N + 2; c++) begin
         @(posedge clk_i);
         #1;
         if (bus.out_valid_o) seen++;
      end
      vectors++;
      if (seen != 0) begin
         errors++;
         $display("FAIL flush_no_valid: valid cycles=%0d required 0", seen);
      end
      // Flush in IDLE blocks a simultaneous request.
      @(negedge clk_i);
      bus.in_valid_i = 1'b1;
      bus.flush_i    = 1'b1;
      @(posedge clk_i);
      #1;
      bus.in_valid_i = 1'b0;
      bus.flush_i    = 1'b0;
      vectors++;
      if (bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle_block: busy=%b required 0", bus.busy_o);
      end
      // Flush beats out_ready in DONE; either way the unit returns to IDLE.
      begin
         int lat;
         issue_and_wait(32'h1, 32'h2, 3'd0, lat);
         @(negedge clk_i);
         bus.flush_i     = 1'b1;
         bus.out_ready_i = 1'b1;
         @(posedge clk_i);
         #1;
         bus.flush_i     = 1'b0;
         bus.out_ready_i = 1'b0;
         vectors++;
         if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: valid=%b ready=%b required 0 1", bus.out_valid_o, bus.in_ready_o);
         end
      end
   endtask

   task automatic test_reset_mid();
      run_op("pre_rst", 32'h7FFFFFFF, 32'h7FFFFFFE, 3'd7);
      @(negedge clk_i);
      bus.in_valid_i = 1'b1;
      bus.op_a_i     = 32'hAAAAAAAA;
      bus.op_b_i     = 32'hAAAAAAAA;
      bus.opcode_i   = 3'd2;
      @(posedge clk_i);
      #1;
      bus.in_valid_i = 1'b0;
      @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      vectors++;
      if (bus.busy_o !== 1'b0 || bus.out_valid_o !== 1'b0 || bus.result_o !== '0 || bus.in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_async: busy=%b valid=%b result=%h ready=%b required 0 0 0 1",
                  bus.busy_o, bus.out_valid_o, bus.result_o, bus.in_ready_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      run_op("post_rst", 32'h00000100, 32'h000000FF, 3'd4);
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b;
      logic [2:0] op;
      for (int k = 0; k < 150; k++) begin
         a  = $urandom;
         op = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: b = a;
            1: b = a ^ (32'h1 << $urandom_range(0, WIDTH - 1));
            2: b = {a[31:16], 16'($urandom)};
            default: b = $urandom;
         endcase
         run_op("random", a, b, op);
      end
   endtask

   initial begin
      bus.flush_i     = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.op_a_i      = '0;
      bus.op_b_i      = '0;
      bus.opcode_i    = '0;
      bus.out_ready_i = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
